// File: rtl/ddr3_traffic_pkg.sv
// +--------------------------------------------------------------------+
// | Module      : ddr3_traffic_pkg                                      |
// | Description : Shared FSM encoding, LFSR constants and status widths |
// |               for the DDR3 loopback traffic generator.              |
// | Revision    : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
`default_nettype none

package ddr3_traffic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } traffic_state_t;

  localparam int ERROR_COUNT_BITWIDTH = 8;

  localparam logic [7:0]  LFSR8_SEED  = 8'hA5;
  localparam logic [7:0]  LFSR8_TAPS  = 8'hB8;
  localparam logic [15:0] LFSR16_SEED = 16'hACE1;
  localparam logic [15:0] LFSR16_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_seed(input int width);
    return (width == 16) ? LFSR16_SEED : {8'h00, LFSR8_SEED};
  endfunction

  function automatic logic [15:0] lfsr_taps(input int width);
    return (width == 16) ? LFSR16_TAPS : {8'h00, LFSR8_TAPS};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ddr3_pattern_gen.sv
// +--------------------------------------------------------------------+
// | Module      : ddr3_pattern_gen                                      |
// | Description : Test-pattern sequencer; counter by default, Galois    |
// |               LFSR when LFSR_PATTERN_EN is defined.                 |
// | Revision    : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
`default_nettype none

module ddr3_pattern_gen
  import ddr3_traffic_pkg::*;
#(
  parameter int DQ_BITWIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   advance,
  output logic [DQ_BITWIDTH-1:0] pattern
);

  logic [DQ_BITWIDTH-1:0] w_next;

`ifdef LFSR_PATTERN_EN
  localparam logic [DQ_BITWIDTH-1:0] c_seed = DQ_BITWIDTH'(lfsr_seed(DQ_BITWIDTH));
  localparam logic [DQ_BITWIDTH-1:0] c_taps = DQ_BITWIDTH'(lfsr_taps(DQ_BITWIDTH));

  // Right-shifting Galois form: the bit shifted out selects the tap mask.
  assign w_next = pattern[0] ? ((pattern >> 1) ^ c_taps) : (pattern >> 1);
`else
  localparam logic [DQ_BITWIDTH-1:0] c_seed = '0;

  assign w_next = pattern + 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern <= '0;
    end else if (load) begin
      pattern <= c_seed;
    end else if (advance) begin
      pattern <= w_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ddr3_loopback_traffic_generator.sv
// +--------------------------------------------------------------------+
// | Module      : ddr3_loopback_traffic_generator                       |
// | Description : Write/read-back/compare stimulus stage ahead of the   |
// |               DDR3 controller. Pattern type set by LFSR_PATTERN_EN. |
// | Revision    : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
`default_nettype none

module ddr3_loopback_traffic_generator
  import ddr3_traffic_pkg::*;
#(
  parameter int DQ_BITWIDTH           = 8,
  parameter int BANK_ADDRESS_BITWIDTH = 3,
  parameter int ADDRESS_BITWIDTH      = 15,
  parameter int NUM_OF_TEST_DATA      = 4,
  parameter int START_ADDRESS         = 0,
  parameter int TIMEOUT_CYCLES        = 65535
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              start,
  input  logic                                              wr_accept,
  input  logic                                              rd_accept,
  input  logic                                              rd_valid,
  input  logic [DQ_BITWIDTH-1:0]                            data_from_ram,
  output logic                                              write_enable,
  output logic                                              read_enable,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]                            data_to_ram,
  output logic                                              busy,
  output logic                                              done_writing,
  output logic                                              done_reading,
  output logic                                              done,
  output logic                                              pass,
  output logic                                              timeout,
  output logic [ERROR_COUNT_BITWIDTH-1:0]                   error_count,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_address
);

  localparam int c_addr_w = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
  localparam int c_wdog_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_addr_w-1:0] c_start = c_addr_w'(START_ADDRESS);
  localparam logic [c_addr_w-1:0] c_last  = c_addr_w'(NUM_OF_TEST_DATA - 1);

  traffic_state_t                  r_state;
  logic [c_addr_w-1:0]             r_wr_idx;
  logic [c_addr_w-1:0]             r_rd_idx;
  logic [c_addr_w-1:0]             r_chk_idx;
  logic [c_wdog_w-1:0]             r_wdog;

  logic [DQ_BITWIDTH-1:0]          w_chk_pattern;
  logic                            w_start_ok;
  logic                            w_wr_last;
  logic                            w_chk_last;
  logic                            w_mismatch;
  logic                            w_activity;
  logic                            w_wdog_expired;
  logic [ERROR_COUNT_BITWIDTH-1:0] w_err_next;

  assign w_start_ok     = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_wr_last      = (r_wr_idx == c_last);
  assign w_chk_last     = (r_chk_idx == c_last);
  assign w_mismatch     = rd_valid && (data_from_ram != w_chk_pattern);
  assign w_activity     = wr_accept || rd_accept || rd_valid;
  assign w_wdog_expired = (r_wdog == c_wdog_w'(TIMEOUT_CYCLES - 1));
  assign w_err_next     = (w_mismatch && error_count != '1)
                        ? error_count + 1'b1 : error_count;

  // Writer and checker run independent copies so reads can overlap checks.
  ddr3_pattern_gen #(.DQ_BITWIDTH(DQ_BITWIDTH)) u_wr_pattern (
    .clk     (clk),
    .reset   (reset),
    .load    (w_start_ok),
    .advance (r_state == ST_WRITE && wr_accept && !w_wr_last),
    .pattern (data_to_ram)
  );

  ddr3_pattern_gen #(.DQ_BITWIDTH(DQ_BITWIDTH)) u_chk_pattern (
    .clk     (clk),
    .reset   (reset),
    .load    (r_state == ST_WRITE && wr_accept && w_wr_last),
    .advance (r_state == ST_READ && rd_valid),
    .pattern (w_chk_pattern)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state             <= ST_IDLE;
      r_wr_idx            <= '0;
      r_rd_idx            <= '0;
      r_chk_idx           <= '0;
      r_wdog              <= '0;
      write_enable        <= 1'b0;
      read_enable         <= 1'b0;
      i_user_data_address <= '0;
      busy                <= 1'b0;
      done_writing        <= 1'b0;
      done_reading        <= 1'b0;
      done                <= 1'b0;
      pass                <= 1'b0;
      timeout             <= 1'b0;
      error_count         <= '0;
      first_error_address <= '0;
    end else begin
      if (w_activity) begin
        r_wdog <= '0;
      end
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state             <= ST_WRITE;
            r_wr_idx            <= '0;
            r_rd_idx            <= '0;
            r_chk_idx           <= '0;
            r_wdog              <= '0;
            write_enable        <= 1'b1;
            read_enable         <= 1'b0;
            i_user_data_address <= c_start;
            busy                <= 1'b1;
            done_writing        <= 1'b0;
            done_reading        <= 1'b0;
            done                <= 1'b0;
            pass                <= 1'b0;
            timeout             <= 1'b0;
            error_count         <= '0;
            first_error_address <= '0;
          end
        end
        ST_WRITE: begin
          if (wr_accept) begin
            if (w_wr_last) begin
              r_state             <= ST_READ;
              write_enable        <= 1'b0;
              done_writing        <= 1'b1;
              read_enable         <= 1'b1;
              i_user_data_address <= c_start;
              r_rd_idx            <= '0;
              r_chk_idx           <= '0;
            end else begin
              r_wr_idx            <= r_wr_idx + 1'b1;
              i_user_data_address <= i_user_data_address + 1'b1;
            end
          end
        end
        ST_READ: begin
          if (rd_accept && read_enable) begin
            i_user_data_address <= i_user_data_address + 1'b1;
            r_rd_idx            <= r_rd_idx + 1'b1;
            if (r_rd_idx == c_last) begin
              read_enable <= 1'b0;
            end
          end
          if (rd_valid) begin
            r_chk_idx   <= r_chk_idx + 1'b1;
            error_count <= w_err_next;
            if (w_mismatch && error_count == '0) begin
              first_error_address <= c_start + r_chk_idx;
            end
            if (w_chk_last) begin
              r_state      <= ST_DONE;
              read_enable  <= 1'b0;
              done_reading <= 1'b1;
              done         <= 1'b1;
              busy         <= 1'b0;
              pass         <= (w_err_next == '0);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Watchdog only counts cycles in which nothing moved while a pass is live.
      if (busy && !w_activity) begin
        if (w_wdog_expired) begin
          r_state      <= ST_DONE;
          timeout      <= 1'b1;
          write_enable <= 1'b0;
          read_enable  <= 1'b0;
          done         <= 1'b1;
          busy         <= 1'b0;
          pass         <= 1'b0;
        end else begin
          r_wdog <= r_wdog + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ddr3_loopback_traffic_generator.sv
// +--------------------------------------------------------------------+
// | Module      : tb_ddr3_loopback_traffic_generator                    |
// | Description : Randomised responder plus reference model for the     |
// |               loopback traffic generator (honours LFSR_PATTERN_EN). |
// | Revision    : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_ddr3_loopback_traffic_generator;

  localparam int DQ    = 8;
  localparam int BA    = 3;
  localparam int AW    = 15;
  localparam int FULL  = BA + AW;
  localparam int N     = 4;
  localparam int START = (1 << FULL) - 2;
  localparam int TO    = 16;

  logic            clk = 1'b0;
  logic            reset, start, wr_accept, rd_accept, rd_valid;
  logic [DQ-1:0]   data_from_ram;
  logic            write_enable, read_enable, busy;
  logic            done_writing, done_reading, done, pass, timeout;
  logic [FULL-1:0] i_user_data_address, first_error_address;
  logic [DQ-1:0]   data_to_ram;
  logic [7:0]      error_count;

  int errors = 0;
  int checks = 0;

  logic [DQ-1:0] mem [logic [FULL-1:0]];

  ddr3_loopback_traffic_generator #(
    .DQ_BITWIDTH          (DQ),
    .BANK_ADDRESS_BITWIDTH(BA),
    .ADDRESS_BITWIDTH     (AW),
    .NUM_OF_TEST_DATA     (N),
    .START_ADDRESS        (START),
    .TIMEOUT_CYCLES       (TO)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .wr_accept           (wr_accept),
    .rd_accept           (rd_accept),
    .rd_valid            (rd_valid),
    .data_from_ram       (data_from_ram),
    .write_enable        (write_enable),
    .read_enable         (read_enable),
    .i_user_data_address (i_user_data_address),
    .data_to_ram         (data_to_ram),
    .busy                (busy),
    .done_writing        (done_writing),
    .done_reading        (done_reading),
    .done                (done),
    .pass                (pass),
    .timeout             (timeout),
    .error_count         (error_count),
    .first_error_address (first_error_address)
  );

  always #5 clk = ~clk;

  // Word i of a pass: plain index, or the LFSR stepped i times from its seed.
  function automatic logic [DQ-1:0] pattern(input int i);
    logic [15:0] s;
    logic [15:0] taps;
`ifdef LFSR_PATTERN_EN
    s    = (DQ == 16) ? 16'hACE1 : 16'h00A5;
    taps = (DQ == 16) ? 16'hB400 : 16'h00B8;
    for (int k = 0; k < i; k++) s = s[0] ? ((s >> 1) ^ taps) : (s >> 1);
`else
    s    = 16'(i);
    taps = '0;
`endif
    return s[DQ-1:0] ^ taps[DQ-1:0] ^ taps[DQ-1:0];
  endfunction

  function automatic logic [FULL-1:0] addr_of(input int k);
    logic [31:0] v;
    v = START + k;
    return v[FULL-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ctl"}, {24'd0, write_enable, read_enable, busy, done_writing,
                        done_reading, done, pass, timeout}, 32'd0);
    chk({tag, "_addr"}, 32'(i_user_data_address), 32'd0);
    chk({tag, "_data"}, 32'(data_to_ram), 32'd0);
    chk({tag, "_err"}, {6'd0, error_count, first_error_address}, 32'd0);
  endtask

  task automatic run_pass(input int corrupt_idx, input int stall_idx, input bit no_valid,
                          input int abort_reads, input bit poke_start);
    int            wr_k = 0, rd_k = 0, chk_k = 0, idle = 0, cyc = 0;
    int            wait_cnt, stall_left, dummy, exp_err;
    bit            fin = 1'b0, tof = 1'b0;
    int            due [$];
    logic [DQ-1:0] vdat [$];
    logic [DQ-1:0] d;

    mem.delete();
    exp_err    = (corrupt_idx >= 0 && corrupt_idx < N && !no_valid) ? 1 : 0;
    wait_cnt   = $urandom_range(0, 2);
    stall_left = 10;
    @(negedge clk);
    start = 1'b1;
    while (!(fin || tof) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; wr_accept = 1'b0; rd_accept = 1'b0; rd_valid = 1'b0;
      data_from_ram = DQ'($urandom);
      chk("busy", 32'(busy), 32'd1);
      chk("wr_en", 32'(write_enable), 32'(wr_k < N));
      chk("rd_en", 32'(read_enable), 32'(wr_k == N && rd_k < N));
      if (write_enable)
        chk("wr_word", {6'd0, i_user_data_address, data_to_ram}, {6'd0, addr_of(wr_k), pattern(wr_k)});
      if (read_enable)
        chk("rd_addr", 32'(i_user_data_address), 32'(addr_of(rd_k)));
      if (abort_reads >= 0 && wr_k == N && rd_k == abort_reads) return;
      if (poke_start && cyc == 3) start = 1'b1;

      if (write_enable && wr_k < N) begin
        if (wr_k == stall_idx && stall_left > 0) stall_left--;
        else if (wait_cnt > 0) wait_cnt--;
        else begin
          wr_accept = 1'b1;
          mem[i_user_data_address] = data_to_ram;
          wr_k++;
          wait_cnt = $urandom_range(0, 2);
        end
      end
      if (read_enable && rd_k < N) begin
        if (wait_cnt > 0) wait_cnt--;
        else begin
          rd_accept = 1'b1;
          vdat.push_back(mem[i_user_data_address]);
          due.push_back(cyc + $urandom_range(1, 4));
          rd_k++;
          wait_cnt = $urandom_range(0, 2);
        end
      end
      if (!no_valid && due.size() > 0 && due[0] <= cyc) begin
        dummy = due.pop_front();
        d = vdat.pop_front();
        rd_valid = 1'b1;
        data_from_ram = (chk_k == corrupt_idx) ? ~d : d;
        chk_k++;
        if (chk_k == N) fin = 1'b1;
      end
      if (wr_accept || rd_accept || rd_valid) idle = 0;
      else begin
        idle++;
        if (idle == TO) tof = 1'b1;
      end
    end

    @(negedge clk);
    start = 1'b0; wr_accept = 1'b0; rd_accept = 1'b0; rd_valid = 1'b0;
    chk("bound", 32'(cyc < 400), 32'd1);
    chk("done", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("timeout", 32'(timeout), 32'(tof));
    chk("pass", 32'(pass), 32'(fin && !tof && exp_err == 0));
    chk("err_cnt", 32'(error_count), 32'(exp_err));
    chk("first_err", 32'(first_error_address), exp_err ? 32'(addr_of(corrupt_idx)) : 32'd0);
    chk("done_wr", 32'(done_writing), 32'(wr_k == N));
    chk("done_rd", 32'(done_reading), 32'(fin));
    chk("enables_end", {30'd0, write_enable, read_enable}, 32'd0);
    @(negedge clk);
    chk("hold", {29'd0, done, pass, timeout}, {29'd1, 1'(fin && !tof && exp_err == 0), tof});
  endtask

  initial begin
    int c;
    reset = 1'b1; start = 1'b0; wr_accept = 1'b0; rd_accept = 1'b0; rd_valid = 1'b0;
    data_from_ram = '0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    reset = 1'b0;

    run_pass(-1, -1, 1'b0, -1, 1'b1);
    run_pass(2, -1, 1'b0, -1, 1'b0);
    run_pass(-1, 1, 1'b0, -1, 1'b0);
    run_pass(-1, -1, 1'b1, -1, 1'b0);

    run_pass(-1, -1, 1'b0, 2, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("mid_rst");
    reset = 1'b0;
    run_pass(-1, -1, 1'b0, -1, 1'b0);

    for (int p = 0; p < 4; p++) begin
      c = $urandom_range(0, N);
      run_pass((c == N) ? -1 : c, -1, 1'b0, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
